// File: rtl/fsm_seq_checker.sv
// Sequence checker for an upstream 8-state counter FSM: locks after LOCK_N good increments,
// flags violations while locked, counts 7->0 laps. Optional err_count via SEQ_CHK_ERRCNT_EN.
module fsm_seq_checker #(
   parameter int unsigned LAP_W  = 8,
   parameter int unsigned LOCK_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       state_in,
   input  logic             state_vld,
   input  logic             clear,
   output logic             locked,
   output logic             err,
   output logic             err_sticky,
`ifdef SEQ_CHK_ERRCNT_EN
   output logic [LAP_W-1:0] lap_count,
   output logic [7:0]       err_count
`else
   output logic [LAP_W-1:0] lap_count
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

   logic [1:0]       state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [3:0]       run_cnt_q, run_cnt_d;
   logic [LAP_W-1:0] lap_q, lap_d;
   logic             err_d, sticky_d, locked_d;
   logic [2:0]       next_code;
   logic             match;
   logic [3:0]       run_inc;

   assign next_code = prev_q + 3'd1;
   assign match     = (state_in == next_code);
   assign run_inc   = run_cnt_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      run_cnt_d = run_cnt_q;
      lap_d     = lap_q;
      err_d     = 1'b0;
      sticky_d  = err_sticky;
      // clear wins over a coincident sample, which is dropped entirely (prev included)
      if (clear) begin
         state_d   = ST_IDLE;
         run_cnt_d = 4'd0;
         lap_d     = '0;
         sticky_d  = 1'b0;
      end else if (state_vld) begin
         prev_d = state_in;
         case (state_q)
            ST_IDLE: begin
               run_cnt_d = 4'd0;
               state_d   = ST_SYNC;
            end
            ST_SYNC: begin
               if (match) begin
                  run_cnt_d = run_inc;
                  if (run_inc == LOCK_CNT) state_d = ST_TRACK;
               end else begin
                  run_cnt_d = 4'd0;
               end
            end
            ST_TRACK: begin
               if (match) begin
                  if (prev_q == 3'd7) lap_d = lap_q + LAP_W'(1);
               end else begin
                  state_d  = ST_ERR;
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
               end
            end
            default: begin
               run_cnt_d = 4'd0;
               state_d   = ST_SYNC;
            end
         endcase
      end
      locked_d = (state_d == ST_TRACK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prev_q     <= 3'd0;
         run_cnt_q  <= 4'd0;
         lap_q      <= '0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         run_cnt_q  <= run_cnt_d;
         lap_q      <= lap_d;
         locked     <= locked_d;
         err        <= err_d;
         err_sticky <= sticky_d;
      end
   end

   assign lap_count = lap_q;

`ifdef SEQ_CHK_ERRCNT_EN
   // Counts in step with the err register so both become visible on the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= 8'd0;
      end else if (clear) begin
         err_count <= 8'd0;
      end else if (err_d && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule
